// File: rtl/bit_count_scan_if.sv
// Switch/select/LED bundle for the bit-count scan unit.
// The master drives the operand and mode; the slave returns the registered result.
interface bit_count_scan_if #(
    parameter int unsigned WIDTH = 7
);
    logic [WIDTH-1:0] sw;
    logic             sel;
    logic [WIDTH-1:0] led;

    modport master (
        output sw,
        output sel,
        input  led
    );

    modport slave (
        input  sw,
        input  sel,
        output led
    );
endinterface

// File: rtl/bit_count_scan.sv
// Registered bit analysis of a switch word.
// sel=0 gives the popcount; sel=1 gives the run length of ones from bit 0.
module bit_count_scan #(
    parameter int unsigned WIDTH = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    bit_count_scan_if.slave   bus
);
    logic [WIDTH-1:0] pop_count;
    logic [WIDTH-1:0] run_length;
    logic             running;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] led_q;

    // Both counts come from one bounded scan; the run stops at the first zero.
    always_comb begin
        pop_count  = '0;
        run_length = '0;
        running    = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (bus.sw[i]) begin
                pop_count = pop_count + WIDTH'(1);
            end
            if (running && bus.sw[i]) begin
                run_length = run_length + WIDTH'(1);
            end else begin
                running = 1'b0;
            end
        end
        result = bus.sel ? run_length : pop_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= result;
        end
    end

    assign bus.led = led_q;
endmodule

// File: tb/tb_bit_count_scan.sv
// Directed bench for bit_count_scan: reset, popcount, run length, mode switching.
module tb_bit_count_scan;
    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    bit_count_scan_if #(.WIDTH(7)) bus ();

    bit_count_scan #(.WIDTH(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        bus.sw = 7'b1111111;
        bus.sel = 1'b0;
        #2;
        compared++;
        if (bus.led !== 7'b0000000) begin
            mismatched++;
            $display("FAIL reset_initial: got %b want %b", bus.led, 7'b0000000);
        end
        step();
        compared++;
        if (bus.led !== 7'b0000000) begin
            mismatched++;
            $display("FAIL reset_hold: got %b want %b", bus.led, 7'b0000000);
        end
        #3 rst_n = 1'b1;
        step();
        compared++;
        if (bus.led !== 7'b0000111) begin
            mismatched++;
            $display("FAIL reset_first_update: got %b want %b", bus.led, 7'b0000111);
        end
        #3 rst_n = 1'b0;
        #1;
        compared++;
        if (bus.led !== 7'b0000000) begin
            mismatched++;
            $display("FAIL reset_async_clear: got %b want %b", bus.led, 7'b0000000);
        end
        step();
        compared++;
        if (bus.led !== 7'b0000000) begin
            mismatched++;
            $display("FAIL reset_held_low: got %b want %b", bus.led, 7'b0000000);
        end
        #3 rst_n = 1'b1;
        #1;
        compared++;
        if (bus.led !== 7'b0000000) begin
            mismatched++;
            $display("FAIL reset_release_no_edge: got %b want %b", bus.led, 7'b0000000);
        end
        step();
        compared++;
        if (bus.led !== 7'b0000111) begin
            mismatched++;
            $display("FAIL reset_release_edge: got %b want %b", bus.led, 7'b0000111);
        end
    endtask

    task automatic test_popcount();
        logic [6:0] exp_tab [9];
        exp_tab = '{7'd0, 7'd1, 7'd1, 7'd2, 7'd1, 7'd2, 7'd2, 7'd3, 7'd1};
        bus.sel = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.sw = 7'(i);
            step();
            compared++;
            if (bus.led !== exp_tab[i]) begin
                mismatched++;
                $display("FAIL popcount sw=%b: got %b want %b", bus.sw, bus.led, exp_tab[i]);
            end
        end
    endtask

    task automatic test_run_length();
        logic [6:0] sw_tab [8];
        sw_tab = '{7'b0000000, 7'b0000001, 7'b0000011, 7'b0000111,
                   7'b0001111, 7'b0011111, 7'b0111111, 7'b1111111};
        bus.sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.sw = sw_tab[i];
            step();
            compared++;
            if (bus.led !== 7'(i)) begin
                mismatched++;
                $display("FAIL run_length sw=%b: got %b want %b", bus.sw, bus.led, 7'(i));
            end
        end
    endtask

    task automatic test_terminating_zero();
        logic [6:0] sw_tab  [6];
        logic       sel_tab [6];
        logic [6:0] exp_tab [6];
        sw_tab  = '{7'b1111110, 7'b1110111, 7'b1111110, 7'b1110111, 7'b1000001, 7'b1000001};
        sel_tab = '{1'b1,       1'b1,       1'b0,       1'b0,       1'b1,       1'b0};
        exp_tab = '{7'd0,       7'd3,       7'd6,       7'd6,       7'd1,       7'd2};
        for (int i = 0; i < 6; i++) begin
            bus.sw  = sw_tab[i];
            bus.sel = sel_tab[i];
            step();
            compared++;
            if (bus.led !== exp_tab[i]) begin
                mismatched++;
                $display("FAIL term_zero sw=%b sel=%b: got %b want %b",
                         bus.sw, bus.sel, bus.led, exp_tab[i]);
            end
        end
    endtask

    task automatic test_mode_switch();
        bus.sw  = 7'b1011011;
        bus.sel = 1'b0;
        step();
        compared++;
        if (bus.led !== 7'd5) begin
            mismatched++;
            $display("FAIL mode_pop: got %b want %b", bus.led, 7'd5);
        end
        #2 bus.sel = 1'b1;
        #1;
        compared++;
        if (bus.led !== 7'd5) begin
            mismatched++;
            $display("FAIL mode_latency: got %b want %b", bus.led, 7'd5);
        end
        step();
        compared++;
        if (bus.led !== 7'd2) begin
            mismatched++;
            $display("FAIL mode_run: got %b want %b", bus.led, 7'd2);
        end
        #2 bus.sel = 1'b0;
        step();
        compared++;
        if (bus.led !== 7'd5) begin
            mismatched++;
            $display("FAIL mode_back_to_pop: got %b want %b", bus.led, 7'd5);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] sw_tab  [5];
        logic       sel_tab [5];
        logic [6:0] exp_tab [5];
        sw_tab  = '{7'b1111111, 7'b0101011, 7'b0101011, 7'b0011111, 7'b1100000};
        sel_tab = '{1'b1,       1'b0,       1'b1,       1'b0,       1'b1};
        exp_tab = '{7'd7,       7'd4,       7'd2,       7'd5,       7'd0};
        for (int i = 0; i < 5; i++) begin
            bus.sw  = sw_tab[i];
            bus.sel = sel_tab[i];
            step();
            compared++;
            if (bus.led !== exp_tab[i]) begin
                mismatched++;
                $display("FAIL back_to_back[%0d]: got %b want %b", i, bus.led, exp_tab[i]);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_popcount();
        test_run_length();
        test_terminating_zero();
        test_mode_switch();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
